// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared types and helpers for the UART frame receive controller.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHK, HOLD} frm_state_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  function automatic logic [7:0] chk_upd(input logic [7:0] chk, input logic [7:0] b);
    return chk ^ b;
  endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte-stream input and frame read port of the frame receive controller.
interface uart_rx_frame_ctrl_if #(parameter int ADDR_W = 4);
  logic              s_tick;
  logic              rx_done;
  logic [7:0]        rx_data;
  logic              frm_valid;
  logic [7:0]        frm_len;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              frm_ack;

  modport master (output s_tick, rx_done, rx_data, rd_addr, frm_ack,
                  input  frm_valid, frm_len, rd_data);
  modport slave  (input  s_tick, rx_done, rx_data, rd_addr, frm_ack,
                  output frm_valid, frm_len, rd_data);
endinterface

// File: rtl/uart_rx_frame_ctrl_frame_buf.sv
// Payload store: MAX_LEN x 8 register array, one write port, registered read port.
module frame_buf #(
  parameter int MAX_LEN = 16,
  parameter int ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [MAX_LEN];

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame receive controller: SOF/LEN/payload/XOR-checksum parser with held-frame read port.
// Optional inter-byte timeout enabled by defining FRAME_TIMEOUT_EN.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int         MAX_LEN   = 16,
  parameter logic [7:0] SOF_BYTE  = SOF_DEFAULT,
  parameter int         TMO_TICKS = 640
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_rx_frame_ctrl_if.slave  bus,
  output logic                 busy,
  output logic                 err_len,
  output logic                 err_chk,
  output logic                 err_ovf,
  output logic                 err_tmo
);

  localparam int         ADDR_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  frm_state_t state, state_n;
  logic [7:0] len, len_n, chk, chk_n, idx, idx_n, frm_len_q, frm_len_n;
  logic       wr_en, tmo_hit;
  logic       err_len_n, err_chk_n, err_ovf_n;

  assign busy          = (state == LEN) || (state == PAYLOAD) || (state == CHK);
  assign bus.frm_valid = (state == HOLD);
  assign bus.frm_len   = frm_len_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      len       <= '0;
      chk       <= '0;
      idx       <= '0;
      frm_len_q <= '0;
      err_len   <= 1'b0;
      err_chk   <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      state     <= state_n;
      len       <= len_n;
      chk       <= chk_n;
      idx       <= idx_n;
      frm_len_q <= frm_len_n;
      err_len   <= err_len_n;
      err_chk   <= err_chk_n;
      err_ovf   <= err_ovf_n;
    end
  end

  always_comb begin
    state_n   = state;
    len_n     = len;
    chk_n     = chk;
    idx_n     = idx;
    frm_len_n = frm_len_q;
    wr_en     = 1'b0;
    err_len_n = 1'b0;
    err_chk_n = 1'b0;
    err_ovf_n = 1'b0;
    unique case (state)
      IDLE: if (bus.rx_done && bus.rx_data == SOF_BYTE) state_n = LEN;
      LEN: if (bus.rx_done) begin
        len_n = bus.rx_data;
        chk_n = bus.rx_data;
        idx_n = '0;
        if (bus.rx_data > MAX_LEN_B) begin
          err_len_n = 1'b1;
          state_n   = IDLE;
        end else if (bus.rx_data == 8'd0) begin
          state_n = CHK;
        end else begin
          state_n = PAYLOAD;
        end
      end
      PAYLOAD: if (bus.rx_done) begin
        wr_en = 1'b1;
        chk_n = chk_upd(chk, bus.rx_data);
        idx_n = idx + 8'd1;
        if (idx + 8'd1 == len) state_n = CHK;
      end
      CHK: if (bus.rx_done) begin
        if (bus.rx_data == chk) begin
          state_n   = HOLD;
          frm_len_n = len;
        end else begin
          err_chk_n = 1'b1;
          state_n   = IDLE;
        end
      end
      HOLD: begin
        // A byte landing during ack is dropped, never treated as a new SOF.
        if (bus.rx_done) err_ovf_n = 1'b1;
        if (bus.frm_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Expiry beats any byte arriving in the same cycle.
    if (tmo_hit) begin
      state_n   = IDLE;
      wr_en     = 1'b0;
      err_len_n = 1'b0;
      err_chk_n = 1'b0;
      frm_len_n = frm_len_q;
    end
  end

`ifdef FRAME_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_TICKS + 1);
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = busy && bus.s_tick && (tmo_cnt == TMO_W'(TMO_TICKS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
      err_tmo <= 1'b0;
    end else begin
      err_tmo <= tmo_hit;
      if (bus.rx_done || state_n == IDLE) tmo_cnt <= '0;
      else if (busy && bus.s_tick)       tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err_tmo = 1'b0;
`endif

  frame_buf #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (idx[ADDR_W-1:0]),
    .wr_data (bus.rx_data),
    .rd_addr (bus.rd_addr),
    .rd_data (bus.rd_data)
  );

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed and randomized frames against a frame-level reference model.
module tb_uart_rx_frame_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic busy, err_len, err_chk, err_ovf, err_tmo;
  int   checks = 0;
  int   errors = 0;

  // Reference model: bytes collected since SOF, and the held frame.
  logic [7:0] cur[$];
  bit         held;
  int         held_len;
  logic [7:0] pay[16];

  always #5 clk = ~clk;

  uart_rx_frame_ctrl_if #(.ADDR_W(4)) bus();

  uart_rx_frame_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .busy    (busy),
    .err_len (err_len),
    .err_chk (err_chk),
    .err_ovf (err_ovf),
    .err_tmo (err_tmo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model(input logic [7:0] b, input bit ack, output bit el, output bit ec, output bit eo);
    int         n;
    logic [7:0] x;
    el = 0; ec = 0; eo = 0;
    if (held) begin
      eo = 1;
      if (ack) held = 0;
    end else if (cur.size() == 0) begin
      if (b == 8'hA5) cur.push_back(b);
    end else begin
      cur.push_back(b);
      n = cur.size();
      if (n == 2 && b > 8'd16) begin
        el = 1;
        cur.delete();
      end else if (n >= 3 && n == int'(cur[1]) + 3) begin
        x = 8'h00;
        for (int i = 1; i < n - 1; i++) x = x ^ cur[i];
        if (x == b) begin
          held     = 1;
          held_len = int'(cur[1]);
          for (int i = 0; i < held_len; i++) pay[i] = cur[2 + i];
        end else begin
          ec = 1;
        end
        cur.delete();
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input bit ack);
    bit el, ec, eo;
    bus.rx_data = b; bus.rx_done = 1'b1; bus.frm_ack = ack;
    step();
    bus.rx_done = 1'b0; bus.frm_ack = 1'b0;
    model(b, ack, el, ec, eo);
    check("err_len", err_len, el);
    check("err_chk", err_chk, ec);
    check("err_ovf", err_ovf, eo);
    check("err_tmo", err_tmo, 0);
    check("frm_valid", bus.frm_valid, held);
    check("busy", busy, cur.size() != 0);
    if (held) check("frm_len", bus.frm_len, held_len);
    step();
    check("err_pulse_end", {err_len, err_chk, err_ovf, err_tmo}, 0);
  endtask

  task automatic send_seq(input logic [7:0] q[$]);
    foreach (q[i]) send(q[i], 1'b0);
  endtask

  task automatic read_all();
    for (int i = 0; i < held_len; i++) begin
      bus.rd_addr = 4'(i);
      step();
      check("rd_data", bus.rd_data, pay[i]);
    end
  endtask

  task automatic ack_frame();
    bus.frm_ack = 1'b1;
    step();
    bus.frm_ack = 1'b0;
    held = 0;
    check("ack_valid", bus.frm_valid, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check(tag, {bus.frm_valid, bus.frm_len, bus.rd_data, busy, err_len, err_chk, err_ovf, err_tmo}, 0);
  endtask

  initial begin
    logic [7:0] q[$];
    int         len, kind;
    logic [7:0] x, b;

    reset = 1'b1;
    bus.s_tick = 1'b0; bus.rx_done = 1'b0; bus.rx_data = '0;
    bus.rd_addr = '0; bus.frm_ack = 1'b0;
    held = 0; held_len = 0;
    repeat (3) step();
    check_idle_outputs("reset_outputs");
    reset = 1'b0;
    step();

    // Good frame, then overflow while held, then release.
    send_seq('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
    check("t1_len_const", bus.frm_len, 3);
    read_all();
    send(8'h42, 1'b0);
    read_all();
    ack_frame();

    // Bad checksum, then good frame.
    send_seq('{8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00});
    send_seq('{8'hA5, 8'h02, 8'hAA, 8'h55, 8'hFD});
    check("t2_valid_const", bus.frm_valid, 1);
    read_all();
    ack_frame();

    // Junk before SOF, zero-length frame.
    send_seq('{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00});
    check("t3_len_const", bus.frm_len, 0);
    ack_frame();

    // Oversize LEN, then a one-byte frame; ack with a concurrent SOF byte.
    send_seq('{8'hA5, 8'h11});
    send_seq('{8'hA5, 8'h01, 8'h7E, 8'h7F});
    read_all();
    send(8'hA5, 1'b1);

    // Ack outside HOLD is ignored.
    bus.frm_ack = 1'b1;
    step();
    bus.frm_ack = 1'b0;
    check("stray_ack", {bus.frm_valid, busy}, 0);

    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        send(b, 1'b0);
      end
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        send_seq('{8'hA5, 8'($urandom_range(17, 255))});
      end else begin
        len = $urandom_range(0, 16);
        q = '{8'hA5, 8'(len)};
        x = 8'(len);
        for (int i = 0; i < len; i++) begin
          b = 8'($urandom_range(0, 255));
          q.push_back(b);
          x = x ^ b;
        end
        if (kind == 1) x = x ^ 8'($urandom_range(1, 255));
        q.push_back(x);
        send_seq(q);
      end
      if (held) begin
        if ($urandom_range(0, 2) == 0) send(8'($urandom_range(0, 255)), 1'b0);
        read_all();
        if ($urandom_range(0, 3) == 0) send(8'($urandom_range(0, 255)), 1'b1);
        else ack_frame();
      end
    end

    // Stalled frame.
    send_seq('{8'hA5, 8'h03, 8'h11});
    bus.s_tick = 1'b1;
`ifdef FRAME_TIMEOUT_EN
    repeat (639) step();
    check("tmo_before", busy, 1);
    step();
    bus.s_tick = 1'b0;
    cur.delete();
    check("tmo_pulse", err_tmo, 1);
    check("tmo_busy", busy, 0);
    step();
    check("tmo_pulse_end", err_tmo, 0);
`else
    repeat (640) step();
    bus.s_tick = 1'b0;
    check("stall_busy", busy, 1);
    check("stall_tmo", err_tmo, 0);
`endif
    reset = 1'b1;
    step();
    cur.delete();
    held = 0;
    check_idle_outputs("reset_midframe");
    reset = 1'b0;
    step();
    send_seq('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32});
    check("post_reset_valid", bus.frm_valid, 1);
    read_all();
    ack_frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
